// File: rtl/row_pipe_nstage_uram.sv
// Row-wide word memory: NUM_WR lanes x NUM_MUL words with a fixed-latency read path (PIPE_STAGES+2).
// Define ROW_PIPE_WR_FWD_EN for write-first same-edge collisions; the default build is read-first.
module row_pipe_nstage_uram #(
  parameter int NUM_MUL     = 4,
  parameter int NUM_WR      = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int KEY_WIDTH   = 32,
  parameter int PIPE_STAGES = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_WR*NUM_MUL-1:0]             arbiter_result,
  input  logic [NUM_WR-1:0]                     write_reg_0_valid,
  input  logic [NUM_WR*INDEX_WIDTH-1:0]         write_reg_0_index,
  input  logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  write_reg_11_xor,
  input  logic [INDEX_WIDTH-1:0]                rd_index,
  input  logic [KEY_WIDTH-1:0]                  rd_key,
  input  logic [1:0]                            rd_opt,
  output logic [NUM_MUL*NUM_WR*DATA_WIDTH-1:0]  rd_out_all_update_next_stage,
  output logic [KEY_WIDTH-1:0]                  rd_key_out_next_stage,
  output logic [1:0]                            rd_opt_out_next_stage,
  output logic                                  rd_valid_next_stage
);

  localparam int NUM_WORDS = NUM_WR * NUM_MUL;
  localparam int DEPTH     = 1 << INDEX_WIDTH;
  localparam int ROW_WIDTH = NUM_WORDS * DATA_WIDTH;
  localparam int LAT       = PIPE_STAGES + 2;

  logic [ROW_WIDTH-1:0] rd_row;

  // One synchronous-read memory per word; the read register doubles as the first pipeline stage.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    localparam int LANE = w / NUM_MUL;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DATA_WIDTH-1:0]  rd_q;
    logic                   we;
    logic [INDEX_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]  wr_word;

    assign we      = !reset && write_reg_0_valid[LANE] && arbiter_result[w];
    assign wr_addr = write_reg_0_index[LANE*INDEX_WIDTH +: INDEX_WIDTH];
    assign wr_word = write_reg_11_xor[w*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
      if (we) begin
        mem[wr_addr] <= wr_word;
      end
    end

`ifdef ROW_PIPE_WR_FWD_EN
    always_ff @(posedge clk) begin
      if (we && (wr_addr == rd_index)) begin
        rd_q <= wr_word;
      end else begin
        rd_q <= mem[rd_index];
      end
    end
`else
    always_ff @(posedge clk) begin
      rd_q <= mem[rd_index];
    end
`endif

    assign rd_row[w*DATA_WIDTH +: DATA_WIDTH] = rd_q;
  end

  // Internal data stages carry no reset; validity is governed by the opt pipeline.
  logic [ROW_WIDTH-1:0] data_pipe [1:LAT-1];

  always_ff @(posedge clk) begin
    data_pipe[1] <= rd_row;
    for (int s = 2; s < LAT; s++) begin
      data_pipe[s] <= data_pipe[s-1];
    end
  end

  logic [KEY_WIDTH-1:0] key_pipe [0:LAT-1];
  logic [1:0]           opt_pipe [0:LAT-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < LAT; s++) begin
        key_pipe[s] <= '0;
        opt_pipe[s] <= '0;
      end
      rd_key_out_next_stage        <= '0;
      rd_opt_out_next_stage        <= '0;
      rd_valid_next_stage          <= 1'b0;
      rd_out_all_update_next_stage <= '0;
    end else begin
      key_pipe[0] <= rd_key;
      opt_pipe[0] <= rd_opt;
      for (int s = 1; s < LAT; s++) begin
        key_pipe[s] <= key_pipe[s-1];
        opt_pipe[s] <= opt_pipe[s-1];
      end
      rd_key_out_next_stage        <= key_pipe[LAT-1];
      rd_opt_out_next_stage        <= opt_pipe[LAT-1];
      rd_valid_next_stage          <= (opt_pipe[LAT-1] != 2'd0);
      rd_out_all_update_next_stage <= data_pipe[LAT-1];
    end
  end

endmodule

// File: tb/tb_row_pipe_nstage_uram.sv
// Randomized and directed bench for row_pipe_nstage_uram against an associative-array memory model.
// Follows ROW_PIPE_WR_FWD_EN to choose write-first or read-first expectations.
module tb_row_pipe_nstage_uram;

  localparam int NM = 4, NW = 8, IW = 12, DW = 64, KW = 32, PS = 3;
  localparam int NWORDS = NM * NW;
  localparam int ROWW   = NWORDS * DW;
  localparam int LAT    = PS + 2;
  localparam int DEPTH  = 1 << IW;
  localparam int SNM = 2, SNW = 2, SIW = 4, SDW = 16;
  localparam int SROWW = SNM * SNW * SDW;
`ifdef ROW_PIPE_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [NWORDS-1:0]   arb;
  logic [NW-1:0]       wr_valid;
  logic [NW*IW-1:0]    wr_index;
  logic [ROWW-1:0]     wr_data;
  logic [IW-1:0]       rd_index;
  logic [KW-1:0]       rd_key;
  logic [1:0]          rd_opt;
  logic [ROWW-1:0]     rd_out;
  logic [KW-1:0]       key_out;
  logic [1:0]          opt_out;
  logic                valid_out;

  logic [SNM*SNW-1:0]  s_arb;
  logic [SNW-1:0]      s_valid;
  logic [SNW*SIW-1:0]  s_index;
  logic [SROWW-1:0]    s_data;
  logic [SIW-1:0]      s_rd_index;
  logic [KW-1:0]       s_rd_key;
  logic [1:0]          s_rd_opt;
  logic [SROWW-1:0]    l0_data, l8_data;
  logic [KW-1:0]       l0_key, l8_key;
  logic [1:0]          l0_opt, l8_opt;
  logic                l0_valid, l8_valid;

  row_pipe_nstage_uram #(
    .NUM_MUL(NM), .NUM_WR(NW), .INDEX_WIDTH(IW), .DATA_WIDTH(DW), .KEY_WIDTH(KW), .PIPE_STAGES(PS)
  ) dut (
    .clk(clk), .reset(reset),
    .arbiter_result(arb), .write_reg_0_valid(wr_valid), .write_reg_0_index(wr_index),
    .write_reg_11_xor(wr_data), .rd_index(rd_index), .rd_key(rd_key), .rd_opt(rd_opt),
    .rd_out_all_update_next_stage(rd_out), .rd_key_out_next_stage(key_out),
    .rd_opt_out_next_stage(opt_out), .rd_valid_next_stage(valid_out)
  );

  row_pipe_nstage_uram #(
    .NUM_MUL(SNM), .NUM_WR(SNW), .INDEX_WIDTH(SIW), .DATA_WIDTH(SDW), .KEY_WIDTH(KW), .PIPE_STAGES(0)
  ) dut_lat0 (
    .clk(clk), .reset(reset),
    .arbiter_result(s_arb), .write_reg_0_valid(s_valid), .write_reg_0_index(s_index),
    .write_reg_11_xor(s_data), .rd_index(s_rd_index), .rd_key(s_rd_key), .rd_opt(s_rd_opt),
    .rd_out_all_update_next_stage(l0_data), .rd_key_out_next_stage(l0_key),
    .rd_opt_out_next_stage(l0_opt), .rd_valid_next_stage(l0_valid)
  );

  row_pipe_nstage_uram #(
    .NUM_MUL(SNM), .NUM_WR(SNW), .INDEX_WIDTH(SIW), .DATA_WIDTH(SDW), .KEY_WIDTH(KW), .PIPE_STAGES(8)
  ) dut_lat8 (
    .clk(clk), .reset(reset),
    .arbiter_result(s_arb), .write_reg_0_valid(s_valid), .write_reg_0_index(s_index),
    .write_reg_11_xor(s_data), .rd_index(s_rd_index), .rd_key(s_rd_key), .rd_opt(s_rd_opt),
    .rd_out_all_update_next_stage(l8_data), .rd_key_out_next_stage(l8_key),
    .rd_opt_out_next_stage(l8_opt), .rd_valid_next_stage(l8_valid)
  );

  typedef struct {
    logic [ROWW-1:0] data;
    logic [ROWW-1:0] mask;
    logic [KW-1:0]   key;
    logic [1:0]      opt;
  } exp_t;

  exp_t            sb[$];
  logic [DW-1:0]   mem_model [int];
  int              checks = 0;
  int              errors = 0;

  task automatic idle_inputs();
    arb = '0; wr_valid = '0; wr_index = '0; wr_data = '0;
    rd_index = '0; rd_key = '0; rd_opt = '0;
    s_arb = '0; s_valid = '0; s_index = '0; s_data = '0;
    s_rd_index = '0; s_rd_key = '0; s_rd_opt = '0;
  endtask

  // One clock: model the read sampled at this edge, apply writes, then compare the output due now.
  task automatic step();
    exp_t e;
    int lane;
    logic [IW-1:0] waddr;
    logic [DW-1:0] wdat;
    bit hit, shown;
    @(posedge clk);
    if (!reset) begin
      e.key = rd_key; e.opt = rd_opt; e.data = '0; e.mask = '0;
      for (int w = 0; w < NWORDS; w++) begin
        lane  = w / NM;
        waddr = wr_index[lane*IW +: IW];
        wdat  = wr_data[w*DW +: DW];
        hit   = wr_valid[lane] && arb[w] && (waddr == rd_index);
        if (FWD && hit) begin
          e.data[w*DW +: DW] = wdat;
          e.mask[w*DW +: DW] = '1;
        end else if (mem_model.exists(w*DEPTH + int'(rd_index))) begin
          e.data[w*DW +: DW] = mem_model[w*DEPTH + int'(rd_index)];
          e.mask[w*DW +: DW] = '1;
        end
      end
      for (int w = 0; w < NWORDS; w++) begin
        lane = w / NM;
        if (wr_valid[lane] && arb[w])
          mem_model[w*DEPTH + int'(wr_index[lane*IW +: IW])] = wr_data[w*DW +: DW];
      end
      sb.push_back(e);
    end
    @(negedge clk);
    if (!reset && sb.size() > LAT) begin
      e = sb.pop_front();
      checks++;
      if (opt_out !== e.opt) begin
        errors++; $display("[TB] FAIL sb_opt: got %0d expected %0d", opt_out, e.opt);
      end
      checks++;
      if (key_out !== e.key) begin
        errors++; $display("[TB] FAIL sb_key: got %h expected %h", key_out, e.key);
      end
      checks++;
      if (valid_out !== (e.opt != 2'd0)) begin
        errors++; $display("[TB] FAIL sb_valid: got %b expected %b", valid_out, e.opt != 2'd0);
      end
      checks++;
      if (((rd_out ^ e.data) & e.mask) !== '0) begin
        errors++; shown = 1'b0;
        for (int w = 0; w < NWORDS; w++) begin
          if (!shown && ((rd_out[w*DW +: DW] ^ e.data[w*DW +: DW]) & e.mask[w*DW +: DW]) != '0) begin
            shown = 1'b1;
            $display("[TB] FAIL sb_data word %0d: got %h expected %h", w, rd_out[w*DW +: DW], e.data[w*DW +: DW]);
          end
        end
      end
    end
  endtask

  task automatic release_reset();
    exp_t z;
    z.data = '0; z.mask = '0; z.key = '0; z.opt = '0;
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < LAT; i++) sb.push_back(z);
  endtask

  task automatic check_outputs_zero(string tag);
    checks++;
    if (opt_out !== 2'd0 || valid_out !== 1'b0 || key_out !== '0 || rd_out !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got opt=%0d valid=%b key=%h expected all zero", tag, opt_out, valid_out, key_out);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset_async");
    step(); step();
    check_outputs_zero("reset_held");
    idle_inputs();
    release_reset();
    step(); step();
  endtask

  task automatic test_single_write();
    idle_inputs();
    wr_valid[2] = 1'b1; arb[2*NM+1] = 1'b1;
    wr_index[2*IW +: IW] = IW'(5); wr_data[(2*NM+1)*DW +: DW] = 64'hAAAA;
    step();
    idle_inputs(); step(); step();
    rd_index = IW'(5); rd_opt = 2'd1; rd_key = 32'h11;
    step();
    idle_inputs();
    for (int n = 1; n <= LAT; n++) step();
    checks++;
    if (valid_out !== 1'b1 || key_out !== 32'h11 || rd_out[(2*NM+1)*DW +: DW] !== 64'hAAAA) begin
      errors++;
      $display("[TB] FAIL single_read: got valid=%b key=%h word=%h expected 1 11 aaaa",
               valid_out, key_out, rd_out[(2*NM+1)*DW +: DW]);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    idle_inputs();
    wr_valid[0] = 1'b1; arb[0] = 1'b1; wr_index[0 +: IW] = IW'(7); wr_data[0 +: DW] = '0;
    step();
    idle_inputs(); step();
    wr_valid[0] = 1'b1; arb[0] = 1'b1; wr_index[0 +: IW] = IW'(7); wr_data[0 +: DW] = 64'h1234;
    rd_index = IW'(7); rd_opt = 2'd2; rd_key = 32'h22;
    step();
    idle_inputs();
    for (int n = 1; n <= LAT; n++) step();
    want = FWD ? 64'h1234 : 64'h0;
    checks++;
    if (rd_out[0 +: DW] !== want || valid_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collision: got word=%h valid=%b expected %h 1", rd_out[0 +: DW], valid_out, want);
    end
    rd_index = IW'(7); rd_opt = 2'd1;
    step();
    idle_inputs();
    for (int n = 1; n <= LAT; n++) step();
  endtask

  task automatic test_lane_disable();
    idle_inputs();
    wr_valid[1] = 1'b1; wr_index[1*IW +: IW] = IW'(10);
    for (int j = 0; j < NM; j++) begin
      arb[NM+j] = 1'b1;
      wr_data[(NM+j)*DW +: DW] = 64'h1111 * (j + 1);
    end
    step();
    idle_inputs();
    arb = '1;
    for (int i = 0; i < NW; i++) wr_index[i*IW +: IW] = IW'(10);
    for (int w = 0; w < NWORDS; w++) wr_data[w*DW +: DW] = 64'hFF;
    step();
    idle_inputs();
    rd_index = IW'(10); rd_opt = 2'd3; rd_key = 32'h33;
    step();
    idle_inputs();
    for (int n = 1; n <= LAT; n++) step();
    for (int j = 0; j < NM; j++) begin
      checks++;
      if (rd_out[(NM+j)*DW +: DW] !== 64'h1111 * (j + 1)) begin
        errors++;
        $display("[TB] FAIL lane_disable word %0d: got %h expected %h", NM+j, rd_out[(NM+j)*DW +: DW], 64'h1111 * (j + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int t = 0; t < 16 + LAT + 1; t++) begin
      if (t < 16) begin
        rd_index = IW'($urandom_range(0, 15)); rd_key = KW'(t); rd_opt = 2'((t % 3) + 1);
      end else begin
        idle_inputs();
      end
      step();
      if (t >= LAT && t < LAT + 16) begin
        checks++;
        if (valid_out !== 1'b1 || key_out !== KW'(t - LAT)) begin
          errors++;
          $display("[TB] FAIL b2b t=%0d: got valid=%b key=%0d expected 1 %0d", t, valid_out, key_out, t - LAT);
        end
      end else if (t == LAT + 16) begin
        checks++;
        if (valid_out !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_end: got valid=%b expected 0", valid_out);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    wr_valid[0] = 1'b1; arb[0] = 1'b1; wr_index[0 +: IW] = IW'(9); wr_data[0 +: DW] = 64'hBEEF;
    step();
    idle_inputs();
    for (int r = 0; r < 3; r++) begin
      rd_index = IW'(5 + 2*r); rd_key = KW'(32'h31 + r); rd_opt = 2'd1;
      step();
    end
    idle_inputs();
    #2 reset = 1'b1;
    #1 check_outputs_zero("midstream_reset");
    wr_valid[0] = 1'b1; arb[0] = 1'b1; wr_index[0 +: IW] = IW'(9); wr_data[0 +: DW] = 64'hDEAD;
    step(); step();
    idle_inputs();
    release_reset();
    for (int n = 0; n <= LAT; n++) begin
      step();
      checks++;
      if (valid_out !== 1'b0) begin
        errors++; $display("[TB] FAIL stale_valid n=%0d: got %b expected 0", n, valid_out);
      end
    end
    rd_index = IW'(9); rd_opt = 2'd1; rd_key = 32'h44;
    step();
    idle_inputs();
    for (int n = 1; n <= LAT; n++) step();
    checks++;
    if (rd_out[0 +: DW] !== 64'hBEEF || key_out !== 32'h44) begin
      errors++;
      $display("[TB] FAIL mem_intact: got word=%h key=%h expected beef 44", rd_out[0 +: DW], key_out);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      wr_valid = NW'($urandom);
      arb      = NWORDS'($urandom);
      for (int i = 0; i < NW; i++) wr_index[i*IW +: IW] = IW'($urandom_range(0, 15));
      for (int b = 0; b < ROWW/32; b++) wr_data[b*32 +: 32] = $urandom;
      rd_index = IW'($urandom_range(0, 15));
      rd_key   = $urandom;
      rd_opt   = 2'($urandom_range(0, 3));
      step();
    end
    idle_inputs();
    for (int n = 0; n < LAT; n++) step();
  endtask

  task automatic test_latency();
    int n0, n8;
    logic [KW-1:0]  k0, k8;
    logic [SDW-1:0] d0, d8;
    idle_inputs();
    s_valid[0] = 1'b1; s_arb[0] = 1'b1; s_index[0 +: SIW] = SIW'(3); s_data[0 +: SDW] = 16'h5A5A;
    step();
    idle_inputs();
    s_rd_index = SIW'(3); s_rd_opt = 2'd1; s_rd_key = 32'hA5;
    step();
    idle_inputs();
    n0 = -1; n8 = -1; k0 = '0; k8 = '0; d0 = '0; d8 = '0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n0 < 0 && l0_valid) begin n0 = n; k0 = l0_key; d0 = l0_data[0 +: SDW]; end
      if (n8 < 0 && l8_valid) begin n8 = n; k8 = l8_key; d8 = l8_data[0 +: SDW]; end
    end
    checks++;
    if (n0 != 2) begin errors++; $display("[TB] FAIL lat0_edges: got %0d expected 2", n0); end
    checks++;
    if (n8 != 10) begin errors++; $display("[TB] FAIL lat8_edges: got %0d expected 10", n8); end
    checks++;
    if (k0 !== 32'hA5 || d0 !== 16'h5A5A) begin
      errors++; $display("[TB] FAIL lat0_payload: got key=%h data=%h expected a5 5a5a", k0, d0);
    end
    checks++;
    if (k8 !== 32'hA5 || d8 !== 16'h5A5A) begin
      errors++; $display("[TB] FAIL lat8_payload: got key=%h data=%h expected a5 5a5a", k8, d8);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_collision();
    test_lane_disable();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/row_pipe_nstage_uram.md
ROW_PIPE_NSTAGE_URAM -- requirements
Module: row_pipe_nstage_uram

Interface
REQ-001 SHALL have parameter NUM_MUL, default 4, words per lane.
REQ-002 SHALL have parameter NUM_WR, default 8, lanes per row.
REQ-003 SHALL have parameter INDEX_WIDTH, default 12, row address width; depth 2^INDEX_WIDTH.
REQ-004 SHALL have parameter DATA_WIDTH, default 64, word width.
REQ-005 SHALL have parameter KEY_WIDTH, default 32, key tag width.
REQ-006 SHALL have parameter PIPE_STAGES, default 3, legal 0..8, extra read-path registers.
REQ-007 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-008 SHALL have reset  input  1  asynchronous, active-high.
REQ-009 SHALL have arbiter_result  input  NUM_WR*NUM_MUL  word write enables; bit i*NUM_MUL+j = lane i word j.
REQ-010 SHALL have write_reg_0_valid  input  NUM_WR  per-lane write valid.
REQ-011 SHALL have write_reg_0_index  input  NUM_WR*INDEX_WIDTH  per-lane write address, lane i at slice i.
REQ-012 SHALL have write_reg_11_xor  input  NUM_MUL*NUM_WR*DATA_WIDTH  write data, word (i,j) at slice i*NUM_MUL+j.
REQ-013 SHALL have rd_index  input  INDEX_WIDTH  read address, common to all lanes.
REQ-014 SHALL have rd_key  input  KEY_WIDTH  tag travelling with read.
REQ-015 SHALL have rd_opt  input  2  operation code; 0 = no read.
REQ-016 SHALL have rd_out_all_update_next_stage  output  NUM_MUL*NUM_WR*DATA_WIDTH  read data, same packing as write data.
REQ-017 SHALL have rd_key_out_next_stage  output  KEY_WIDTH  delayed rd_key.
REQ-018 SHALL have rd_opt_out_next_stage  output  2  delayed rd_opt.
REQ-019 SHALL have rd_valid_next_stage  output  1  high when rd_opt_out_next_stage != 0.

Function
REQ-020 SHALL hold NUM_WR*NUM_MUL independent word memories, each 2^INDEX_WIDTH x DATA_WIDTH.
REQ-021 SHALL write word (i,j) at write_reg_0_index lane i with its data when write_reg_0_valid[i] and arbiter_result[i*NUM_MUL+j] both high at an edge; other words unchanged.
REQ-022 SHALL ignore arbiter_result bits of a lane whose valid is low.
REQ-023 SHALL read all words at rd_index every cycle regardless of rd_opt.
REQ-024 SHALL present data, key and opt sampled at edge k on outputs after edge k+LAT, LAT = PIPE_STAGES+2, fixed, no stall.
REQ-025 SHALL keep data, key, opt of one read aligned in same output cycle; back-to-back reads every cycle sustained.
REQ-026 SHALL return per word, for a write at edge k-1 or earlier to rd_index, the written value (write-before-read across cycles).
REQ-027 SHALL, for a write and read to same word and index at same edge k, return per REQ-041/REQ-042.
REQ-028 SHALL treat writes after edge k as invisible to the read sampled at edge k.
REQ-029 SHALL update rd_valid_next_stage in the same cycle as rd_opt_out_next_stage.
REQ-030 SHALL with PIPE_STAGES=0 give LAT=2 with no extra registers.

Reset
REQ-031 SHALL on reset assertion immediately clear all opt pipeline registers, rd_opt_out_next_stage, rd_valid_next_stage to 0.
REQ-032 SHALL on reset clear rd_key_out_next_stage and rd_out_all_update_next_stage to 0.
REQ-033 SHALL not clear memory contents on reset.
REQ-034 SHALL discard reads in flight at reset; first valid output no earlier than LAT edges after a read sampled post-deassertion.
REQ-035 SHALL block writes on edges where reset is high.

Configuration
REQ-040 SHALL use macro ROW_PIPE_WR_FWD_EN.
REQ-041 SHALL with ROW_PIPE_WR_FWD_EN defined return same-edge write data (write-first bypass, per word).
REQ-042 SHALL without it return pre-write contents for same-edge collisions (read-first); LAT unchanged either way.

Verification
REQ-050 SHALL cover: write lane 2 word 1 index 0x05 = 0xAAAA, later read 0x05 opt=1 key=0x11 -> after 5 edges word(2,1)=0xAAAA, key 0x11, valid=1.
REQ-051 SHALL cover: same-edge write 0x1234 and read at index 0x07 over old 0x0 -> 0x1234 with macro, 0x0 without.
REQ-052 SHALL cover: lane valid=0 with all arbiter bits high, data 0xFF -> read back unchanged contents.
REQ-053 SHALL cover: 16 consecutive reads keys 0..15, opt=1..3 cycling -> outputs keys 0..15 in order on consecutive cycles, valid continuous.
REQ-054 SHALL cover: reset asserted mid-stream with 3 reads in flight -> outputs 0 immediately, no stale valid after release; memory data intact.
REQ-055 SHALL cover: PIPE_STAGES=0 and 8 -> latency 2 and 10 edges respectively.
